alu_issue_queue: RTL and testbench
==================================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports: CLK  in  1  clock; RST  in  1  synchronous active-high reset.
REQ-003 SHALL have dispatch inputs: dispatch_valid 1; dispatch_op 4; dispatch_is_imm 1; dispatch_imm 32; dispatch_A_unneeded 1; dispatch_A_ready 1; dispatch_A_PR LOG_PR_COUNT; dispatch_B_ready 1; dispatch_B_PR LOG_PR_COUNT; dispatch_dest_PR LOG_PR_COUNT; dispatch_ROB_index LOG_ROB_ENTRIES.
REQ-004 SHALL have dispatch_ready  out  1  queue can accept an entry this cycle.
REQ-005 SHALL have wakeup inputs: WB_bus_valid  in  1; WB_bus_PR  in  LOG_PR_COUNT  PR written back this cycle.
REQ-006 SHALL have issue outputs to the ALU pipeline: issue_valid 1; issue_op 4; issue_is_imm 1; issue_imm 32; issue_A_unneeded 1; issue_A_forward 1; issue_A_bank LOG_PRF_BANK_COUNT; issue_B_forward 1; issue_B_bank LOG_PRF_BANK_COUNT; issue_dest_PR LOG_PR_COUNT; issue_ROB_index LOG_ROB_ENTRIES.
REQ-007 SHALL have issue_ready  in  1  pipeline accepts an op this cycle.
REQ-008 SHALL have PRF read-request outputs: PRF_req_A_valid 1; PRF_req_A_PR LOG_PR_COUNT; PRF_req_B_valid 1; PRF_req_B_PR LOG_PR_COUNT.

Function
REQ-009 SHALL hold ALU_IQ_ENTRIES (8) entries as a compressing age-ordered queue; index 0 oldest.
REQ-010 SHALL accept dispatch when dispatch_valid & dispatch_ready, writing to the lowest free index after this cycle's compression.
REQ-011 SHALL drive dispatch_ready = ~valid[ALU_IQ_ENTRIES-1] (registered occupancy; an issue in the same cycle does not raise it).
REQ-012 SHALL treat operand B as unneeded when is_imm=1; A as unneeded when A_unneeded=1; unneeded operands count as ready.
REQ-013 SHALL set a stored operand ready bit when WB_bus_valid and WB_bus_PR equals that operand's PR.
REQ-014 SHALL store an operand ready at dispatch if dispatch_X_ready=1 or it matches the WB bus in the dispatch cycle.
REQ-015 SHALL consider an entry issuable when valid and each operand is ready-bit-set or matches the WB bus this cycle.
REQ-016 SHALL select the lowest-index issuable entry; issue_valid = issue_ready & any issuable; a newly dispatched entry issues no earlier than the next cycle.
REQ-017 SHALL set issue_X_forward=1 iff that needed operand's ready bit is clear and it matches the WB bus this cycle.
REQ-018 SHALL drive issue_X_bank = operand PR[LOG_PRF_BANK_COUNT-1:0]; issue payload = selected entry fields.
REQ-019 SHALL assert PRF_req_X_valid with issue_valid when operand X is needed and not forwarded; PRF_req_X_PR = operand PR.
REQ-020 SHALL remove the issued entry the same cycle, shifting all younger entries down by one, keeping ready bits and WB-bus updates.
REQ-021 SHALL drive all issue/PRF_req outputs to 0 when issue_valid=0.
REQ-022 SHALL support simultaneous dispatch, wakeup and issue in one cycle without loss or duplication.

Reset
REQ-023 SHALL, on RST high at a clock edge, clear all valid and ready bits; in-flight entries are discarded.
REQ-024 SHALL present after reset: dispatch_ready=1, issue_valid=0, all issue and PRF_req outputs 0.
REQ-025 SHALL ignore dispatch and WB bus on any cycle where RST is high.

Structure
REQ-026 SHALL take LOG_PR_COUNT (6), LOG_ROB_ENTRIES (6), PRF_BANK_COUNT (4), LOG_PRF_BANK_COUNT (2) from core_types_pkg; ALU_IQ_ENTRIES and the entry struct SHALL be added there.
REQ-027 SHALL use one sub-module, pe_lsb, a parameterized lowest-set-bit priority encoder for issue selection.

Verification
REQ-028 Reset then idle -> dispatch_ready=1, issue_valid=0 for 2 cycles.
REQ-029 Dispatch ADD dest p2, A p0 ready, B p1 ready, issue_ready=1 -> next cycle issue_valid=1, A_bank 0, B_bank 1, PRF_req A p0 / B p1, forwards 0.
REQ-030 Dispatch SLT A p5 not-ready, B p6 ready; next cycle WB_bus p5 -> same cycle issue_valid=1, A_forward=1, A_bank 1, PRF_req_A_valid=0, PRF_req_B p6.
REQ-031 Fill 8 entries with A not ready, issue_ready=1 -> dispatch_ready=0 after 8th; WB p-match for entry 3 -> entry 3 issues, dispatch_ready=1 next cycle, order of remaining preserved.
REQ-032 Two ready entries (ROB 4 older, ROB 5), issue_ready=0 for 2 cycles -> issue_valid=0; issue_ready=1 -> ROB 4 then ROB 5 on consecutive cycles.
REQ-033 RST asserted with 3 valid entries -> next cycle issue_valid=0, dispatch_ready=1, later WB bus matches cause no issue.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core type definitions.
// Holds the physical-register, ROB and PRF-bank widths used across the core,
// plus the ALU issue-queue depth and the per-entry storage struct.
package core_types_pkg;

  localparam int LOG_PR_COUNT       = 6;
  localparam int LOG_ROB_ENTRIES    = 6;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;

  localparam int ALU_IQ_ENTRIES     = 8;
  localparam int LOG_ALU_IQ_ENTRIES = 3;

  // One issue-queue slot. A_ready/B_ready track only the physical operand;
  // whether the operand is needed at all is carried by A_unneeded / is_imm.
  typedef struct packed {
    logic                       valid;
    logic [3:0]                 op;
    logic                       is_imm;
    logic [31:0]                imm;
    logic                       A_unneeded;
    logic                       A_ready;
    logic [LOG_PR_COUNT-1:0]    A_PR;
    logic                       B_ready;
    logic [LOG_PR_COUNT-1:0]    B_PR;
    logic [LOG_PR_COUNT-1:0]    dest_PR;
    logic [LOG_ROB_ENTRIES-1:0] ROB_index;
  } alu_iq_entry_t;

  // PRF bank of a physical register: the low bits of its number.
  function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(
    input logic [LOG_PR_COUNT-1:0] pr
  );
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

endpackage

// File: rtl/pe_lsb.sv
// Lowest-set-bit priority encoder.
// Ports:
//   req   - request vector, bit 0 has highest priority
//   found - at least one request bit is set
//   idx   - index of the lowest set bit (0 when found=0)
module pe_lsb #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: compressing, age-ordered (index 0 oldest) queue of
// ALU_IQ_ENTRIES slots. Operands wake up from the writeback bus; the oldest
// entry whose operands are all ready issues, and younger entries shift down.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising CLK edge. dispatch_ready depends only on registered
// occupancy; issue_valid already includes issue_ready, so issue_valid=1 means
// the op is transferred and removed this cycle.
//
// Ports:
//   CLK, RST                - clock, synchronous active-high reset
//   dispatch_*              - new entry from rename/dispatch
//   dispatch_ready          - queue has a free slot (top slot empty)
//   WB_bus_valid/WB_bus_PR  - physical register written back this cycle
//   issue_*                 - selected op to the ALU pipeline
//   issue_ready             - ALU pipeline can take an op this cycle
//   PRF_req_A/B_*           - register-file reads for non-forwarded operands
module alu_issue_queue
  import core_types_pkg::*;
(
  input  logic                          CLK,
  input  logic                          RST,

  input  logic                          dispatch_valid,
  input  logic [3:0]                    dispatch_op,
  input  logic                          dispatch_is_imm,
  input  logic [31:0]                   dispatch_imm,
  input  logic                          dispatch_A_unneeded,
  input  logic                          dispatch_A_ready,
  input  logic [LOG_PR_COUNT-1:0]       dispatch_A_PR,
  input  logic                          dispatch_B_ready,
  input  logic [LOG_PR_COUNT-1:0]       dispatch_B_PR,
  input  logic [LOG_PR_COUNT-1:0]       dispatch_dest_PR,
  input  logic [LOG_ROB_ENTRIES-1:0]    dispatch_ROB_index,
  output logic                          dispatch_ready,

  input  logic                          WB_bus_valid,
  input  logic [LOG_PR_COUNT-1:0]       WB_bus_PR,

  output logic                          issue_valid,
  output logic [3:0]                    issue_op,
  output logic                          issue_is_imm,
  output logic [31:0]                   issue_imm,
  output logic                          issue_A_unneeded,
  output logic                          issue_A_forward,
  output logic [LOG_PRF_BANK_COUNT-1:0] issue_A_bank,
  output logic                          issue_B_forward,
  output logic [LOG_PRF_BANK_COUNT-1:0] issue_B_bank,
  output logic [LOG_PR_COUNT-1:0]       issue_dest_PR,
  output logic [LOG_ROB_ENTRIES-1:0]    issue_ROB_index,
  input  logic                          issue_ready,

  output logic                          PRF_req_A_valid,
  output logic [LOG_PR_COUNT-1:0]       PRF_req_A_PR,
  output logic                          PRF_req_B_valid,
  output logic [LOG_PR_COUNT-1:0]       PRF_req_B_PR
);

  localparam int N = ALU_IQ_ENTRIES;

  alu_iq_entry_t q   [N];  // registered queue
  alu_iq_entry_t q_w [N];  // after wakeup
  alu_iq_entry_t q_c [N];  // after wakeup + compression
  alu_iq_entry_t q_n [N];  // after dispatch insert

  logic                          wb_v;
  logic [N-1:0]                  a_hit, b_hit, issuable;
  logic                          sel_found;
  logic [LOG_ALU_IQ_ENTRIES-1:0] sel_idx;
  alu_iq_entry_t                 sel_e;
  logic                          sel_a_fwd, sel_b_fwd;
  logic                          disp_fire;
  logic                          disp_a_hit, disp_b_hit;

  // The WB bus and dispatch are ignored while reset is asserted.
  assign wb_v           = WB_bus_valid & ~RST;
  assign dispatch_ready = ~q[N-1].valid;
  assign disp_fire      = dispatch_valid & dispatch_ready & ~RST;
  assign disp_a_hit     = wb_v & (WB_bus_PR == dispatch_A_PR);
  assign disp_b_hit     = wb_v & (WB_bus_PR == dispatch_B_PR);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_hit[i]    = wb_v & (WB_bus_PR == q[i].A_PR);
      b_hit[i]    = wb_v & (WB_bus_PR == q[i].B_PR);
      issuable[i] = q[i].valid
                  & (q[i].A_unneeded | q[i].A_ready | a_hit[i])
                  & (q[i].is_imm     | q[i].B_ready | b_hit[i]);
    end
  end

  pe_lsb #(.WIDTH(N), .IDX_W(LOG_ALU_IQ_ENTRIES)) u_sel (
    .req   (issuable),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign issue_valid = issue_ready & sel_found & ~RST;
  assign sel_e       = q[sel_idx];
  // Forward only a needed operand that became ready on this very cycle.
  assign sel_a_fwd   = ~sel_e.A_unneeded & ~sel_e.A_ready & a_hit[sel_idx];
  assign sel_b_fwd   = ~sel_e.is_imm     & ~sel_e.B_ready & b_hit[sel_idx];

  always_comb begin
    issue_op         = '0;
    issue_is_imm     = 1'b0;
    issue_imm        = '0;
    issue_A_unneeded = 1'b0;
    issue_A_forward  = 1'b0;
    issue_A_bank     = '0;
    issue_B_forward  = 1'b0;
    issue_B_bank     = '0;
    issue_dest_PR    = '0;
    issue_ROB_index  = '0;
    PRF_req_A_valid  = 1'b0;
    PRF_req_A_PR     = '0;
    PRF_req_B_valid  = 1'b0;
    PRF_req_B_PR     = '0;
    if (issue_valid) begin
      issue_op         = sel_e.op;
      issue_is_imm     = sel_e.is_imm;
      issue_imm        = sel_e.imm;
      issue_A_unneeded = sel_e.A_unneeded;
      issue_A_forward  = sel_a_fwd;
      issue_A_bank     = pr_bank(sel_e.A_PR);
      issue_B_forward  = sel_b_fwd;
      issue_B_bank     = pr_bank(sel_e.B_PR);
      issue_dest_PR    = sel_e.dest_PR;
      issue_ROB_index  = sel_e.ROB_index;
      PRF_req_A_valid  = ~sel_e.A_unneeded & ~sel_a_fwd;
      PRF_req_A_PR     = sel_e.A_PR;
      PRF_req_B_valid  = ~sel_e.is_imm & ~sel_b_fwd;
      PRF_req_B_PR     = sel_e.B_PR;
    end
  end

  // Next-state: wakeup, then remove the issued slot, then append dispatch.
  always_comb begin
    logic placed;
    for (int i = 0; i < N; i++) begin
      q_w[i]         = q[i];
      q_w[i].A_ready = q[i].A_ready | a_hit[i];
      q_w[i].B_ready = q[i].B_ready | b_hit[i];
    end

    for (int i = 0; i < N - 1; i++) begin
      if (issue_valid && (LOG_ALU_IQ_ENTRIES'(i) >= sel_idx)) q_c[i] = q_w[i+1];
      else                                                    q_c[i] = q_w[i];
    end
    if (issue_valid) q_c[N-1] = '0;
    else             q_c[N-1] = q_w[N-1];

    // Valid slots are contiguous from 0, so the first empty slot is the tail.
    placed = 1'b0;
    for (int i = 0; i < N; i++) begin
      q_n[i] = q_c[i];
      if (disp_fire && !placed && !q_c[i].valid) begin
        q_n[i].valid      = 1'b1;
        q_n[i].op         = dispatch_op;
        q_n[i].is_imm     = dispatch_is_imm;
        q_n[i].imm        = dispatch_imm;
        q_n[i].A_unneeded = dispatch_A_unneeded;
        q_n[i].A_ready    = dispatch_A_ready | disp_a_hit;
        q_n[i].A_PR       = dispatch_A_PR;
        q_n[i].B_ready    = dispatch_B_ready | disp_b_hit;
        q_n[i].B_PR       = dispatch_B_PR;
        q_n[i].dest_PR    = dispatch_dest_PR;
        q_n[i].ROB_index  = dispatch_ROB_index;
        placed            = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) q[i] <= q_n[i];
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
  import core_types_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic                          dispatch_valid;
  logic [3:0]                    dispatch_op;
  logic                          dispatch_is_imm;
  logic [31:0]                   dispatch_imm;
  logic                          dispatch_A_unneeded;
  logic                          dispatch_A_ready;
  logic [LOG_PR_COUNT-1:0]       dispatch_A_PR;
  logic                          dispatch_B_ready;
  logic [LOG_PR_COUNT-1:0]       dispatch_B_PR;
  logic [LOG_PR_COUNT-1:0]       dispatch_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]    dispatch_ROB_index;
  logic                          dispatch_ready;
  logic                          WB_bus_valid;
  logic [LOG_PR_COUNT-1:0]       WB_bus_PR;
  logic                          issue_valid;
  logic [3:0]                    issue_op;
  logic                          issue_is_imm;
  logic [31:0]                   issue_imm;
  logic                          issue_A_unneeded;
  logic                          issue_A_forward;
  logic [LOG_PRF_BANK_COUNT-1:0] issue_A_bank;
  logic                          issue_B_forward;
  logic [LOG_PRF_BANK_COUNT-1:0] issue_B_bank;
  logic [LOG_PR_COUNT-1:0]       issue_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]    issue_ROB_index;
  logic                          issue_ready;
  logic                          PRF_req_A_valid;
  logic [LOG_PR_COUNT-1:0]       PRF_req_A_PR;
  logic                          PRF_req_B_valid;
  logic [LOG_PR_COUNT-1:0]       PRF_req_B_PR;

  alu_issue_queue dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .dispatch_valid      (dispatch_valid),
    .dispatch_op         (dispatch_op),
    .dispatch_is_imm     (dispatch_is_imm),
    .dispatch_imm        (dispatch_imm),
    .dispatch_A_unneeded (dispatch_A_unneeded),
    .dispatch_A_ready    (dispatch_A_ready),
    .dispatch_A_PR       (dispatch_A_PR),
    .dispatch_B_ready    (dispatch_B_ready),
    .dispatch_B_PR       (dispatch_B_PR),
    .dispatch_dest_PR    (dispatch_dest_PR),
    .dispatch_ROB_index  (dispatch_ROB_index),
    .dispatch_ready      (dispatch_ready),
    .WB_bus_valid        (WB_bus_valid),
    .WB_bus_PR           (WB_bus_PR),
    .issue_valid         (issue_valid),
    .issue_op            (issue_op),
    .issue_is_imm        (issue_is_imm),
    .issue_imm           (issue_imm),
    .issue_A_unneeded    (issue_A_unneeded),
    .issue_A_forward     (issue_A_forward),
    .issue_A_bank        (issue_A_bank),
    .issue_B_forward     (issue_B_forward),
    .issue_B_bank        (issue_B_bank),
    .issue_dest_PR       (issue_dest_PR),
    .issue_ROB_index     (issue_ROB_index),
    .issue_ready         (issue_ready),
    .PRF_req_A_valid     (PRF_req_A_valid),
    .PRF_req_A_PR        (PRF_req_A_PR),
    .PRF_req_B_valid     (PRF_req_B_valid),
    .PRF_req_B_PR        (PRF_req_B_PR)
  );

  // ---------------- scoreboard ----------------
  localparam int VW = 70;
  logic [VW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  // Expected issue packet built from hand-chosen fields; banks are PR low bits,
  // PRF reads are requested for needed operands that are not forwarded.
  function automatic logic [VW-1:0] mk_exp(input int op, input int is_imm,
      input logic [31:0] imm, input int a_un, input int a_fwd, input int a_pr,
      input int b_fwd, input int b_pr, input int dest, input int rob);
    logic [5:0] ap;
    logic [5:0] bp;
    ap = 6'(a_pr);
    bp = 6'(b_pr);
    return {4'(op), 1'(is_imm), imm, 1'(a_un), 1'(a_fwd), ap[1:0], 1'(b_fwd),
            bp[1:0], 6'(dest), 6'(rob), 1'(a_un == 0 && a_fwd == 0), ap,
            1'(is_imm == 0 && b_fwd == 0), bp};
  endfunction

  logic [VW-1:0] act_vec;
  assign act_vec = {issue_op, issue_is_imm, issue_imm, issue_A_unneeded,
                    issue_A_forward, issue_A_bank, issue_B_forward, issue_B_bank,
                    issue_dest_PR, issue_ROB_index, PRF_req_A_valid, PRF_req_A_PR,
                    PRF_req_B_valid, PRF_req_B_PR};

  // Monitor: mid-cycle, pop and compare on every issue; idle outputs must be 0.
  always @(negedge CLK) begin
    logic [VW-1:0] e;
    if (mon_en) begin
      total++;
      if (issue_valid) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL issue_unexpected got=%h", act_vec);
        end else begin
          e = exp_q.pop_front();
          if (act_vec !== e) begin
            bad++;
            $display("FAIL issue_payload got=%h exp=%h", act_vec, e);
          end
        end
      end else if (act_vec !== '0) begin
        bad++;
        $display("FAIL idle_outputs_zero got=%h exp=0", act_vec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic disp(input int op, input int is_imm, input logic [31:0] imm,
      input int a_un, input int a_rdy, input int a_pr, input int b_rdy,
      input int b_pr, input int dest, input int rob);
    dispatch_valid      = 1'b1;
    dispatch_op         = 4'(op);
    dispatch_is_imm     = 1'(is_imm);
    dispatch_imm        = imm;
    dispatch_A_unneeded = 1'(a_un);
    dispatch_A_ready    = 1'(a_rdy);
    dispatch_A_PR       = 6'(a_pr);
    dispatch_B_ready    = 1'(b_rdy);
    dispatch_B_PR       = 6'(b_pr);
    dispatch_dest_PR    = 6'(dest);
    dispatch_ROB_index  = 6'(rob);
  endtask

  task automatic wb(input int v, input int pr);
    WB_bus_valid = 1'(v);
    WB_bus_PR    = 6'(pr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int wake_order[7];
    int issue_order[7];
    wake_order  = '{7, 6, 5, 4, 2, 1, 0};
    issue_order = '{0, 1, 2, 4, 5, 6, 7};

    RST = 1'b1;
    issue_ready = 1'b0;
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dispatch_valid = 1'b0;
    wb(0, 0);
    cyc(); cyc();
    RST = 1'b0;
    mon_en = 1'b1;

    // Reset then idle
    for (int c = 0; c < 2; c++) begin
      cyc(); #2;
      chk("rst_dispatch_ready", 32'(dispatch_ready), 1);
      chk("rst_issue_valid", 32'(issue_valid), 0);
    end

    // Simple ready ADD
    cyc();
    issue_ready = 1'b1;
    disp(0, 0, 0, 0, 1, 0, 1, 1, 2, 1);
    exp_q.push_back(mk_exp(0, 0, 0, 0, 0, 0, 0, 1, 2, 1));
    #2 chk("add_no_same_cycle_issue", 32'(issue_valid), 0);
    cyc();
    dispatch_valid = 1'b0;
    #2 chk("add_issue_valid", 32'(issue_valid), 1);
    cyc(); #2 chk("add_drained", 32'(issue_valid), 0);

    // SLT with A woken and forwarded in the issue cycle
    cyc();
    disp(3, 0, 0, 0, 0, 5, 1, 6, 7, 2);
    cyc();
    dispatch_valid = 1'b0;
    wb(1, 5);
    exp_q.push_back(mk_exp(3, 0, 0, 0, 1, 5, 0, 6, 7, 2));
    #2;
    chk("slt_issue_valid", 32'(issue_valid), 1);
    chk("slt_A_forward", 32'(issue_A_forward), 1);
    chk("slt_PRF_A_valid", 32'(PRF_req_A_valid), 0);
    cyc();
    wb(0, 0);
    #2 chk("slt_drained", 32'(issue_valid), 0);

    // Fill all 8 slots with A not ready
    for (int k = 0; k < 8; k++) begin
      cyc();
      disp(k, 0, 0, 0, 0, 10 + k, 1, 1, 20 + k, 8 + k);
      #2;
      chk("fill_dispatch_ready", 32'(dispatch_ready), 1);
      chk("fill_issue_valid", 32'(issue_valid), 0);
    end
    cyc();
    dispatch_valid = 1'b0;
    #2;
    chk("full_dispatch_ready", 32'(dispatch_ready), 0);
    chk("full_issue_valid", 32'(issue_valid), 0);
    cyc();
    wb(1, 13);
    exp_q.push_back(mk_exp(3, 0, 0, 0, 1, 13, 0, 1, 23, 11));
    #2;
    chk("full_mid_issue_valid", 32'(issue_valid), 1);
    chk("full_ready_stays_low", 32'(dispatch_ready), 0);
    cyc();
    wb(0, 0);
    issue_ready = 1'b0;
    #2 chk("after_issue_dispatch_ready", 32'(dispatch_ready), 1);
    // Wake the rest youngest-first while blocked; they must drain oldest-first.
    for (int j = 0; j < 7; j++) begin
      cyc();
      wb(1, 10 + wake_order[j]);
      #2 chk("blocked_issue_valid", 32'(issue_valid), 0);
    end
    cyc();
    wb(0, 0);
    issue_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      int k;
      k = issue_order[j];
      exp_q.push_back(mk_exp(k, 0, 0, 0, 0, 10 + k, 0, 1, 20 + k, 8 + k));
    end
    for (int j = 0; j < 7; j++) begin
      if (j > 0) cyc();
      #2 chk("drain_issue_valid", 32'(issue_valid), 1);
    end
    cyc(); #2;
    chk("drain_empty", 32'(issue_valid), 0);
    chk("drain_dispatch_ready", 32'(dispatch_ready), 1);

    // Two ready entries held back, then issued in age order
    issue_ready = 1'b0;
    cyc();
    disp(1, 0, 0, 1, 0, 40, 1, 3, 12, 4);
    cyc();
    disp(5, 1, 32'hdeadbeef, 0, 1, 8, 0, 9, 13, 5);
    cyc();
    dispatch_valid = 1'b0;
    #2 chk("hold_issue_valid_0", 32'(issue_valid), 0);
    cyc(); #2 chk("hold_issue_valid_1", 32'(issue_valid), 0);
    cyc();
    issue_ready = 1'b1;
    exp_q.push_back(mk_exp(1, 0, 0, 1, 0, 40, 0, 3, 12, 4));
    exp_q.push_back(mk_exp(5, 1, 32'hdeadbeef, 0, 0, 8, 0, 9, 13, 5));
    #2;
    chk("order_first_valid", 32'(issue_valid), 1);
    chk("order_first_rob", 32'(issue_ROB_index), 4);
    cyc(); #2;
    chk("order_second_valid", 32'(issue_valid), 1);
    chk("order_second_rob", 32'(issue_ROB_index), 5);
    cyc(); #2 chk("order_drained", 32'(issue_valid), 0);

    // Reset discards entries; dispatch/WB during reset are ignored
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      disp(2, 0, 0, 0, 0, 30 + k, 1, 4, 40 + k, 16 + k);
    end
    cyc();
    dispatch_valid = 1'b0;
    #2 chk("pre_rst_issue_valid", 32'(issue_valid), 0);
    cyc();
    RST = 1'b1;
    wb(1, 30);
    disp(6, 0, 0, 0, 1, 1, 1, 2, 3, 20);
    cyc();
    RST = 1'b0;
    dispatch_valid = 1'b0;
    wb(0, 0);
    issue_ready = 1'b1;
    #2;
    chk("post_rst_issue_valid", 32'(issue_valid), 0);
    chk("post_rst_dispatch_ready", 32'(dispatch_ready), 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      wb(1, 30 + k);
      #2 chk("post_rst_wb_no_issue", 32'(issue_valid), 0);
    end
    cyc();
    wb(0, 0);
    #2 chk("post_rst_idle", 32'(issue_valid), 0);

    repeat (3) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
